transaction_fifo: RTL

//  Per-port queue of the transaction layer. Four instances feed the arbiter (input side).

---
 rtl/transaction_fifo_pkg.sv | 20 ++
 rtl/transaction_fifo_if.sv | 28 ++
 rtl/transaction_fifo_mem.sv | 28 ++
 rtl/transaction_fifo.sv | 96 +++++++++
 4 files changed

// File: rtl/transaction_fifo_pkg.sv
// Constants shared by the transaction-layer arbiter and its per-port FIFOs.
// A word carries its destination port in the top bits and its payload in the rest.
package transaction_fifo_pkg;

    localparam int TXN_DATA_W         = 10;
    localparam int TXN_DEST_HI        = 9;
    localparam int TXN_DEST_LO        = 8;
    localparam int TXN_NUM_PORTS      = 4;
    localparam int TXN_FIFO_ADDR_W    = 3;
    localparam int TXN_FIFO_AF_THRESH = 6;
    localparam int TXN_FIFO_AE_THRESH = 1;

    typedef logic [TXN_DATA_W-1:0]              txn_word_t;
    typedef logic [TXN_DEST_HI-TXN_DEST_LO:0]   txn_dest_t;

    function automatic txn_dest_t txn_dest(input txn_word_t word);
        return word[TXN_DEST_HI:TXN_DEST_LO];
    endfunction

endpackage

// File: rtl/transaction_fifo_if.sv
// Push/pop port of a transaction FIFO plus its status flags.
// The master side pushes and pops; the slave side is the FIFO itself.
interface transaction_fifo_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
);
    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, data_in, pop,
        input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/transaction_fifo_mem.sv
// FIFO storage: register file with synchronous write and asynchronous read,
// so the head word is visible without a read cycle.
module transaction_fifo_mem #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; the pointers/count define which entries are valid,
    // and leaving it out keeps this a plain register file with no reset fan-out.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/transaction_fifo.sv
// First-word-fall-through per-port transaction queue: pointers, occupancy,
// threshold flags and sticky error bits around a small register file.
module transaction_fifo
    import transaction_fifo_pkg::*;
#(
    parameter int DATA_W    = TXN_DATA_W,
    parameter int ADDR_W    = TXN_FIFO_ADDR_W,
    parameter int AF_THRESH = TXN_FIFO_AF_THRESH,
    parameter int AE_THRESH = TXN_FIFO_AE_THRESH
) (
    input  logic                clk,
    input  logic                reset,
    transaction_fifo_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              empty, full;
    logic              push_ok, pop_ok;
    logic [DATA_W-1:0] rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));

    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        push_ok     = bus.push & (~full | bus.pop);
        pop_ok      = bus.pop & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (bus.push & ~push_ok);
        underflow_d = underflow_q | (bus.pop & empty);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // A full FIFO accepting push and pop together reads the head slot
    // asynchronously before the edge that overwrites it.
    transaction_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign bus.data_out     = empty ? '0 : rdata;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (count_q <= (ADDR_W+1)'(AE_THRESH));
    assign bus.almost_full  = (count_q >= (ADDR_W+1)'(AF_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
